// File: rtl/ccm_pixel_pipeline_if.sv
// Pixel stream bundle for the colour-correction pipeline: input beats (s_*, bypass)
// and corrected output beats (m_*), each with valid/ready flow control.
interface ccm_pixel_pipeline_if #(
  parameter int LANES = 1,
  parameter int CH_W  = 8
);
  logic [LANES*3*CH_W-1:0] s_rgb;
  logic                    s_sof;
  logic                    s_valid;
  logic                    s_ready;
  logic                    bypass;
  logic [LANES*3*CH_W-1:0] m_rgb;
  logic                    m_sof;
  logic                    m_valid;
  logic                    m_ready;

  modport slave (
    input  s_rgb, s_sof, s_valid, bypass, m_ready,
    output s_ready, m_rgb, m_sof, m_valid
  );

  modport master (
    output s_rgb, s_sof, s_valid, bypass, m_ready,
    input  s_ready, m_rgb, m_sof, m_valid
  );
endinterface

// File: rtl/ccm_pixel_pipeline.sv
// Multi-lane 3x3 colour-correction pipeline with double-buffered matrix,
// per-beat bypass, unsigned channel clamp and per-frame saturation statistics.
module ccm_pixel_pipeline #(
  parameter int LANES     = 1,
  parameter int CH_W      = 8,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9*COEF_W-1:0]   matrix_in,
  input  logic                  matrix_valid,
  ccm_pixel_pipeline_if.slave   px,
  output logic                  matrix_pending,
  output logic [15:0]           sat_frame,
  output logic                  busy
);
  localparam int PX_W   = 3*CH_W;
  localparam int PROD_W = COEF_W + CH_W + 1;
  localparam int SUM_W  = COEF_W + CH_W + 3;
  localparam int SCNT_W = $clog2(3*LANES+1);

  localparam logic [COEF_W-1:0]       ONE_C  = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;
  localparam logic [9*COEF_W-1:0]     IDENT  = {ONE_C, {(3*COEF_W){1'b0}}, ONE_C,
                                                {(3*COEF_W){1'b0}}, ONE_C};
  localparam logic signed [SUM_W-1:0] HALF   = {{(SUM_W-1){1'b0}}, 1'b1} << (COEF_FRAC-1);
  localparam logic signed [SUM_W-1:0] CH_MAX = {{(SUM_W-CH_W){1'b0}}, {CH_W{1'b1}}};

  function automatic logic signed [PROD_W-1:0] mul_px(input logic [CH_W-1:0] pix,
                                                      input logic signed [COEF_W-1:0] cf);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = $signed({{(PROD_W-CH_W){1'b0}}, pix});
    b = PROD_W'(cf);
    return a * b;
  endfunction

  // Returns {clamped_flag, channel}.
  function automatic logic [CH_W:0] clamp_ch(input logic signed [SUM_W-1:0] acc);
    logic signed [SUM_W-1:0] sh;
    sh = acc >>> COEF_FRAC;
    if (sh[SUM_W-1])       return {1'b1, {CH_W{1'b0}}};
    else if (sh > CH_MAX)  return {1'b1, {CH_W{1'b1}}};
    else                   return {1'b0, sh[CH_W-1:0]};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [SCNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic en, accept, xfer, swap;
  logic vld_p0, vld_p1, vld_p2;
  logic [9*COEF_W-1:0] active_mat, shadow_mat, use_mat;

  assign en          = !vld_p2 || px.m_ready;
  assign px.s_ready  = en;
  assign accept      = px.s_valid && en;
  assign xfer        = vld_p2 && px.m_ready;
  assign swap        = accept && px.s_sof && matrix_pending;
  assign busy        = vld_p0 || vld_p1 || vld_p2;
  // The sof beat that triggers a swap already sees the incoming matrix.
  assign use_mat     = swap ? shadow_mat : active_mat;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_mat     <= IDENT;
      shadow_mat     <= IDENT;
      matrix_pending <= 1'b0;
    end else begin
      if (swap) active_mat <= shadow_mat;
      if (matrix_valid) begin
        shadow_mat     <= matrix_in;
        matrix_pending <= 1'b1;
      end else if (swap) begin
        matrix_pending <= 1'b0;
      end
    end
  end

  // ---- stage p0: per-lane products ----
  logic signed [PROD_W-1:0] prod_p0 [LANES][9];
  logic [LANES*PX_W-1:0]    raw_p0;
  logic                     sof_p0, byp_p0;

  always_ff @(posedge clk) begin
    if (rst)     vld_p0 <= 1'b0;
    else if (en) vld_p0 <= px.s_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      raw_p0 <= px.s_rgb;
      sof_p0 <= px.s_sof;
      byp_p0 <= px.bypass;
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            prod_p0[l][r*3+c] <= mul_px(px.s_rgb[l*PX_W + (2-c)*CH_W +: CH_W],
                                        use_mat[(r*3+c)*COEF_W +: COEF_W]);
    end
  end

  // ---- stage p1: rounded row sums ----
  logic signed [SUM_W-1:0] sum_p1 [LANES][3];
  logic [LANES*PX_W-1:0]   raw_p1;
  logic                    sof_p1, byp_p1;

  always_ff @(posedge clk) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (en && vld_p0) begin
      raw_p1 <= raw_p0;
      sof_p1 <= sof_p0;
      byp_p1 <= byp_p0;
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < 3; r++)
          sum_p1[l][r] <= SUM_W'(prod_p0[l][r*3]) + SUM_W'(prod_p0[l][r*3+1])
                        + SUM_W'(prod_p0[l][r*3+2]) + HALF;
    end
  end

  // ---- stage p2: shift, clamp, output register ----
  logic [LANES*PX_W-1:0] rgb_c, rgb_p2;
  logic [SCNT_W-1:0]     cnt_c, cnt_p2;
  logic [CH_W:0]         cl_c;
  logic                  sof_p2;
  logic [15:0]           sat_cnt;

  always_comb begin
    rgb_c = raw_p1;
    cnt_c = '0;
    cl_c  = '0;
    if (!byp_p1) begin
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < 3; r++) begin
          cl_c = clamp_ch(sum_p1[l][r]);
          rgb_c[l*PX_W + (2-r)*CH_W +: CH_W] = cl_c[CH_W-1:0];
          cnt_c = cnt_c + SCNT_W'(cl_c[CH_W]);
        end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= '0;
      sof_p2 <= 1'b0;
      cnt_p2 <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      sof_p2 <= vld_p1 && sof_p1;
      if (vld_p1) begin
        rgb_p2 <= rgb_c;
        cnt_p2 <= cnt_c;
      end
    end
  end

  assign px.m_rgb   = rgb_p2;
  assign px.m_sof   = sof_p2;
  assign px.m_valid = vld_p2;

  // A transferring sof beat closes the previous frame and seeds the new count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt   <= '0;
      sat_frame <= '0;
    end else if (xfer) begin
      if (sof_p2) begin
        sat_frame <= sat_cnt;
        sat_cnt   <= 16'(cnt_p2);
      end else begin
        sat_cnt   <= sat_add(sat_cnt, cnt_p2);
      end
    end
  end
endmodule

// File: tb/tb_ccm_pixel_pipeline.sv
// Directed bench for ccm_pixel_pipeline (LANES=2): identity, matrix swap timing,
// clamp/rounding, saturation statistics, stall ordering, bypass and mid-stream reset.
module tb_ccm_pixel_pipeline;
  localparam int LANES     = 2;
  localparam int CH_W      = 8;
  localparam int COEF_W    = 32;
  localparam int COEF_FRAC = 16;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] NONE = 32'hFFFF_0000;
  localparam logic [31:0] Z    = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [9*COEF_W-1:0] matrix_in;
  logic        matrix_valid;
  logic        matrix_pending;
  logic [15:0] sat_frame;
  logic        busy;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  ccm_pixel_pipeline_if #(.LANES(LANES), .CH_W(CH_W)) px_if ();

  ccm_pixel_pipeline #(
    .LANES(LANES), .CH_W(CH_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .matrix_in(matrix_in),
    .matrix_valid(matrix_valid),
    .px(px_if),
    .matrix_pending(matrix_pending),
    .sat_frame(sat_frame),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] pix(input int r0, g0, b0, r1, g1, b1);
    return {8'(r1), 8'(g1), 8'(b1), 8'(r0), 8'(g0), 8'(b0)};
  endfunction

  function automatic logic [287:0] mat9(input logic [31:0] a00, a01, a02, a10, a11, a12,
                                        a20, a21, a22);
    return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [287:0] m);
    matrix_in    = m;
    matrix_valid = 1'b1;
    step();
    matrix_valid = 1'b0;
  endtask

  // Present one beat, then wait until its output cycle (3 cycles after presentation).
  task automatic xact(input logic sof, input logic byp, input logic [47:0] rgb);
    px_if.s_rgb   = rgb;
    px_if.s_sof   = sof;
    px_if.bypass  = byp;
    px_if.s_valid = 1'b1;
    step();
    px_if.s_valid = 1'b0;
    px_if.s_sof   = 1'b0;
    step();
    chk("lat_early", 64'(px_if.m_valid), 64'(0));
    step();
  endtask

  initial begin
    logic acc;
    int   si, oi, lo;
    logic [47:0] exp_rgb;

    rst = 1'b1;
    matrix_in = '0;
    matrix_valid = 1'b0;
    px_if.s_rgb = '0;
    px_if.s_sof = 1'b0;
    px_if.s_valid = 1'b0;
    px_if.bypass = 1'b0;
    px_if.m_ready = 1'b1;
    step();
    step();
    chk("rst_m_valid", 64'(px_if.m_valid), 64'(0));
    chk("rst_m_rgb", 64'(px_if.m_rgb), 64'(0));
    chk("rst_m_sof", 64'(px_if.m_sof), 64'(0));
    chk("rst_pending", 64'(matrix_pending), 64'(0));
    chk("rst_sat_frame", 64'(sat_frame), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    step();
    chk("rst_s_ready", 64'(px_if.s_ready), 64'(1));

    // Identity pass-through
    xact(1'b1, 1'b0, pix(10, 200, 255, 1, 2, 3));
    chk("id_valid", 64'(px_if.m_valid), 64'(1));
    chk("id_rgb", 64'(px_if.m_rgb), 64'(pix(10, 200, 255, 1, 2, 3)));
    chk("id_sof", 64'(px_if.m_sof), 64'(1));
    step();

    // R/B swap loaded mid-frame, takes effect on next sof
    load(mat9(Z, Z, ONE, Z, ONE, Z, ONE, Z, Z));
    chk("swap_pending", 64'(matrix_pending), 64'(1));
    xact(1'b0, 1'b0, pix(10, 200, 255, 1, 2, 3));
    chk("swap_midframe_rgb", 64'(px_if.m_rgb), 64'(pix(10, 200, 255, 1, 2, 3)));
    chk("swap_midframe_sof", 64'(px_if.m_sof), 64'(0));
    step();
    xact(1'b1, 1'b0, pix(10, 200, 255, 1, 2, 3));
    chk("swap_sof_rgb", 64'(px_if.m_rgb), 64'(pix(255, 200, 10, 3, 2, 1)));
    chk("swap_cleared", 64'(matrix_pending), 64'(0));
    step();

    // Gain 1.5 clamps R; bypass beat raw and uncounted
    load(mat9(32'h18000, Z, Z, Z, 32'h18000, Z, Z, Z, 32'h18000));
    xact(1'b1, 1'b0, pix(200, 100, 0, 0, 0, 0));
    chk("gain_rgb", 64'(px_if.m_rgb), 64'(pix(255, 150, 0, 0, 0, 0)));
    step();
    chk("gain_prev_frame", 64'(sat_frame), 64'(0));
    xact(1'b0, 1'b1, pix(200, 200, 200, 255, 255, 255));
    chk("byp_raw", 64'(px_if.m_rgb), 64'(pix(200, 200, 200, 255, 255, 255)));
    step();
    xact(1'b1, 1'b0, pix(0, 0, 0, 0, 0, 0));
    chk("gain_zero_rgb", 64'(px_if.m_rgb), 64'(0));
    step();
    chk("sat_frame_one", 64'(sat_frame), 64'(1));

    // Round half up at gain 0.5, negative clamp with row0 {1,-1,0}
    load(mat9(32'h8000, Z, Z, Z, 32'h8000, Z, Z, Z, 32'h8000));
    xact(1'b1, 1'b0, pix(3, 1, 0, 255, 4, 7));
    chk("round_rgb", 64'(px_if.m_rgb), 64'(pix(2, 1, 0, 128, 2, 4)));
    step();
    load(mat9(ONE, NONE, Z, Z, ONE, Z, Z, Z, ONE));
    xact(1'b1, 1'b0, pix(50, 100, 0, 100, 50, 9));
    chk("neg_clamp_rgb", 64'(px_if.m_rgb), 64'(pix(0, 100, 0, 50, 50, 9)));
    step();

    // 8 continuous beats under identity with m_ready low in cycles 3-7
    load(mat9(ONE, Z, Z, Z, ONE, Z, Z, Z, ONE));
    si = 0; oi = 0; lo = 0;
    for (int c = 0; c < 40 && oi < 8; c++) begin
      px_if.m_ready = !(c >= 3 && c <= 7);
      px_if.s_valid = (si < 8);
      px_if.s_sof   = (si == 0);
      px_if.bypass  = 1'b0;
      px_if.s_rgb   = pix(si, si+16, si+32, si+64, si+80, si+96);
      #1;
      if (!px_if.m_ready && px_if.m_valid) begin
        chk("stall_s_ready", 64'(px_if.s_ready), 64'(0));
        chk("stall_busy", 64'(busy), 64'(1));
        lo++;
      end
      if (px_if.m_valid && px_if.m_ready) begin
        chk("str_rgb", 64'(px_if.m_rgb), 64'(pix(oi, oi+16, oi+32, oi+64, oi+80, oi+96)));
        chk("str_sof", 64'(px_if.m_sof), 64'(oi == 0));
        oi++;
      end
      acc = px_if.s_valid && px_if.s_ready;
      step();
      if (acc) si++;
    end
    px_if.s_valid = 1'b0;
    px_if.s_sof   = 1'b0;
    px_if.m_ready = 1'b1;
    chk("str_count", 64'(oi), 64'(8));
    chk("stall_cycles", 64'(lo), 64'(5));
    chk("str_idle_busy", 64'(busy), 64'(0));
    chk("str_sat_frame", 64'(sat_frame), 64'(1));

    // Bypass toggled per beat under R/B swap
    load(mat9(Z, Z, ONE, Z, ONE, Z, ONE, Z, Z));
    si = 0; oi = 0;
    for (int c = 0; c < 20 && oi < 4; c++) begin
      px_if.s_valid = (si < 4);
      px_if.s_sof   = (si == 0);
      px_if.bypass  = (si % 2 == 0);
      px_if.s_rgb   = pix(20+si, 100, 200+si, 5, 6, 7);
      #1;
      if (px_if.m_valid) begin
        exp_rgb = (oi % 2 == 0) ? pix(20+oi, 100, 200+oi, 5, 6, 7)
                                : pix(200+oi, 100, 20+oi, 7, 6, 5);
        chk("byp_toggle_rgb", 64'(px_if.m_rgb), 64'(exp_rgb));
        oi++;
      end
      acc = px_if.s_valid && px_if.s_ready;
      step();
      if (acc) si++;
    end
    px_if.s_valid = 1'b0;
    px_if.s_sof   = 1'b0;
    px_if.bypass  = 1'b0;
    chk("byp_count", 64'(oi), 64'(4));

    // Reset mid-stream drops in-flight beats and restores identity
    load(mat9(32'h18000, Z, Z, Z, 32'h18000, Z, Z, Z, 32'h18000));
    px_if.s_valid = 1'b1;
    px_if.s_rgb   = pix(10, 200, 255, 1, 2, 3);
    step();
    step();
    step();
    chk("pre_rst_valid", 64'(px_if.m_valid), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    px_if.s_valid = 1'b0;
    chk("mid_rst_m_valid", 64'(px_if.m_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_m_rgb", 64'(px_if.m_rgb), 64'(0));
    chk("mid_rst_pending", 64'(matrix_pending), 64'(0));
    xact(1'b0, 1'b0, pix(10, 200, 255, 1, 2, 3));
    chk("post_rst_identity", 64'(px_if.m_rgb), 64'(pix(10, 200, 255, 1, 2, 3)));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
